spi_device_ep: RTL and testbench

SPI device (target) endpoint that terminates the SPI host's 4-wire bus inside the same SoC test fabric. It oversamples `spi_sclk`, `spi_mosi` and `spi_cs_n` on the system clock. It deserializes MOSI bytes into a one-cycle `rx_valid` strobe and serializes a pre-loaded response byte onto MISO. Bus timing matches the host: the host drives MOSI on SCLK rise and samples MISO on SCLK fall, MSB first, with SCLK idle low.

---
 rtl/spi_device_ep.sv | 191 +++++++++++++++++++
 tb/tb_spi_device_ep.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_device_ep.sv
// SPI target endpoint: oversamples SCLK/MOSI/CS_N on clk, receives one word per CS frame, returns a pre-loaded word on MISO.
// Optional saturating abort counter enabled by defining SPI_DEV_ABORT_CNT_EN.
module spi_device_ep #(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    SYNC_STAGES = 2,
    parameter logic [DATA_WIDTH-1:0] IDLE_WORD   = 8'hFF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  spi_sclk,
    input  logic                  spi_mosi,
    input  logic                  spi_cs_n,
    output logic                  spi_miso,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  tx_underrun,
    output logic                  frame_abort,
    output logic                  busy,
    output logic [7:0]            abort_cnt
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam int CNT_W   = $clog2(DATA_WIDTH + 1);
    localparam int FLUSH_W = $clog2(SYNC_STAGES + 2);

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [SYNC_STAGES-1:0] sclk_sync_p0, mosi_sync_p0, cs_sync_p0;
    logic                   sclk_d_p1, cs_d_p1;
    logic                   sclk_s, mosi_s, cs_s;
    logic                   sclk_rise, sclk_fall, cs_fall, cs_rise;

    // Stage p0: bus synchronizers; p1: delayed copy for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync_p0 <= '0;
            mosi_sync_p0 <= '0;
            cs_sync_p0   <= '1;
            sclk_d_p1    <= 1'b0;
            cs_d_p1      <= 1'b1;
        end else begin
            sclk_sync_p0 <= {sclk_sync_p0[SYNC_STAGES-2:0], spi_sclk};
            mosi_sync_p0 <= {mosi_sync_p0[SYNC_STAGES-2:0], spi_mosi};
            cs_sync_p0   <= {cs_sync_p0[SYNC_STAGES-2:0], spi_cs_n};
            sclk_d_p1    <= sclk_s;
            cs_d_p1      <= cs_s;
        end
    end

    assign sclk_s    = sclk_sync_p0[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_p0[SYNC_STAGES-1];
    assign cs_s      = cs_sync_p0[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d_p1;
    assign sclk_fall = ~sclk_s & sclk_d_p1;
    assign cs_fall   = ~cs_s & cs_d_p1;
    assign cs_rise   = cs_s & ~cs_d_p1;

    // The synchronizers reset to CS high, so a CS already low at reset release
    // would look like a fresh fall. Frames are accepted only after the chain has
    // flushed and CS has genuinely been seen high.
    logic [FLUSH_W-1:0] flush_cnt;
    logic               flushed;
    logic               cs_armed;

    assign flushed = (flush_cnt == FLUSH_W'(SYNC_STAGES + 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_cnt <= '0;
            cs_armed  <= 1'b0;
        end else begin
            if (!flushed)
                flush_cnt <= flush_cnt + 1'b1;
            if (flushed && cs_s && cs_d_p1)
                cs_armed <= 1'b1;
        end
    end

    logic [1:0]            state;
    logic                  frame_start;
    logic                  tx_accept;
    logic                  hold_full;
    logic [DATA_WIDTH-1:0] hold_data;
    logic [DATA_WIDTH-1:0] tx_shift;
    logic [DATA_WIDTH-1:0] rx_shift;
    logic [DATA_WIDTH-1:0] rx_word;
    logic [CNT_W-1:0]      bit_cnt;
    logic                  last_fall;

    assign frame_start = cs_fall && cs_armed && (state == ST_IDLE);
    assign tx_ready    = !hold_full;
    assign tx_accept   = tx_valid && !hold_full;
    assign busy        = (state != ST_IDLE);
    assign last_fall   = sclk_fall && (bit_cnt == CNT_W'(DATA_WIDTH - 1));
    assign rx_word     = {rx_shift[DATA_WIDTH-2:0], mosi_s};

    // A word accepted in the frame-start cycle stays in the hold for the next frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            hold_full <= 1'b0;
        else if (tx_accept)
            hold_full <= 1'b1;
        else if (frame_start)
            hold_full <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (tx_accept)
            hold_data <= tx_data;
    end

    // Shift datapath: no reset needed, always loaded before use
    always_ff @(posedge clk) begin
        if (frame_start)
            tx_shift <= hold_full ? hold_data : IDLE_WORD;
        else if (state == ST_SHIFT && sclk_rise)
            tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
        if (state == ST_SHIFT && sclk_fall)
            rx_shift <= rx_word;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            spi_miso    <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            frame_abort <= 1'b0;
            case (state)
                ST_IDLE: begin
                    spi_miso <= 1'b0;
                    if (frame_start) begin
                        tx_underrun <= !hold_full;
                        bit_cnt     <= '0;
                        state       <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (sclk_rise)
                        spi_miso <= tx_shift[DATA_WIDTH-1];
                    if (sclk_fall)
                        bit_cnt <= bit_cnt + 1'b1;
                    // A CS release landing on the final fall still completes the word
                    if (last_fall) begin
                        rx_data  <= rx_word;
                        rx_valid <= 1'b1;
                        state    <= cs_rise ? ST_IDLE : ST_DONE;
                    end else if (cs_rise) begin
                        frame_abort <= (bit_cnt != '0) || sclk_fall;
                        state       <= ST_IDLE;
                    end
                end
                ST_DONE: begin
                    if (cs_rise)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef SPI_DEV_ABORT_CNT_EN
    logic [7:0] abort_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            abort_q <= 8'h00;
        else if (frame_abort)
            abort_q <= sat_inc8(abort_q);
    end

    assign abort_cnt = abort_q;
`else
    assign abort_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_spi_device_ep.sv
// Randomized scoreboard bench for spi_device_ep: a host model drives SPI frames,
// expected strobes are queued at issue time and a monitor pops them as the DUT reports.
module tb_spi_device_ep;

    localparam logic [1:0] EV_UND = 2'd0;
    localparam logic [1:0] EV_RX  = 2'd1;
    localparam logic [1:0] EV_ABT = 2'd2;

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] data;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       spi_sclk, spi_mosi, spi_cs_n, spi_miso;
    logic [7:0] tx_data;
    logic       tx_valid, tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid, tx_underrun, frame_abort, busy;
    logic [7:0] abort_cnt;

    spi_device_ep #(.DATA_WIDTH(8), .SYNC_STAGES(2), .IDLE_WORD(8'hFF)) dut (
        .clk(clk), .rst(rst),
        .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_cs_n(spi_cs_n), .spi_miso(spi_miso),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_underrun(tx_underrun), .frame_abort(frame_abort),
        .busy(busy), .abort_cnt(abort_cnt)
    );

    always #5 clk = ~clk;

    ev_t        exp_q[$];
    int         n_vec = 0;
    int         n_err = 0;
    int         half  = 8;
    logic       m_full = 1'b0;
    logic [7:0] m_hold = 8'h00;
    logic [7:0] m_rx   = 8'h00;
    int         m_aborts = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_abort_cnt();
`ifdef SPI_DEV_ABORT_CNT_EN
        return (m_aborts > 255) ? 8'hFF : 8'(m_aborts);
`else
        return 8'h00;
`endif
    endfunction

    task automatic mon_pop(input logic [1:0] k, input logic [7:0] d);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_event: got kind %0d data %0h, expected no event", k, d);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", 32'(k), 32'(e.kind));
            if (k == EV_RX)
                check("rx_data_on_valid", 32'(d), 32'(e.data));
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (tx_underrun) mon_pop(EV_UND, 8'h00);
            if (rx_valid)    mon_pop(EV_RX, rx_data);
            if (frame_abort) mon_pop(EV_ABT, 8'h00);
        end
    end

    task automatic offer(input logic [7:0] d);
        int n = 0;
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = d;
        while (!tx_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            n_vec++;
            n_err++;
            $display("FAIL offer_timeout: got tx_ready 0, expected 1");
        end
        @(negedge clk);
        tx_valid = 1'b0;
        m_full = 1'b1;
        m_hold = d;
        check("tx_ready_after_accept", 32'(tx_ready), 32'd0);
    endtask

    // Host model: one CS frame of nbits bits; the whole expected outcome is queued up front.
    task automatic host_frame(input logic [7:0] mo, input int nbits, input bit cs_on_last,
                              input bit offer_same, input logic [7:0] offer_data);
        logic [7:0] exp_miso;
        logic [7:0] mi;
        ev_t        e;
        int         pre;
        exp_miso = m_full ? m_hold : 8'hFF;
        if (!m_full) begin
            e.kind = EV_UND; e.data = 8'h00; exp_q.push_back(e);
        end
        m_full = 1'b0;
        if (offer_same) begin
            m_full = 1'b1;
            m_hold = offer_data;
        end
        if (nbits == 8) begin
            e.kind = EV_RX; e.data = mo; exp_q.push_back(e);
            m_rx = mo;
        end else if (nbits > 0) begin
            e.kind = EV_ABT; e.data = 8'h00; exp_q.push_back(e);
            m_aborts++;
        end

        @(negedge clk);
        spi_cs_n = 1'b0;
        pre = half;
        if (offer_same) begin
            // cs_fall reaches the FSM on the 3rd clk edge; offer exactly for that edge
            repeat (2) @(negedge clk);
            tx_valid = 1'b1;
            tx_data  = offer_data;
            @(negedge clk);
            tx_valid = 1'b0;
            pre = half - 3 + 1;
        end
        repeat (pre) @(negedge clk);
        check("busy_in_frame", 32'(busy), 32'd1);
        check("tx_ready_after_cs_fall", 32'(tx_ready), 32'(!m_full));

        mi = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = mo[7-i];
            spi_sclk = 1'b1;
            repeat (half) @(negedge clk);
            mi = {mi[6:0], spi_miso};
            spi_sclk = 1'b0;
            if (i == nbits - 1 && cs_on_last)
                spi_cs_n = 1'b1;
            repeat (half) @(negedge clk);
        end
        spi_cs_n = 1'b1;
        repeat (2 * half) @(negedge clk);

        if (nbits > 0)
            check("miso_word", 32'(mi), 32'(exp_miso >> (8 - nbits)));
        check("rx_data_held", 32'(rx_data), 32'(m_rx));
        check("idle_after_frame", 32'({busy, spi_miso}), 32'd0);
        check("tx_ready_level", 32'(tx_ready), 32'(!m_full));
    endtask

    initial begin
        #5ms;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] mo;
        int         nb;
        ev_t        e;

        rst = 1'b1;
        spi_sclk = 1'b0; spi_mosi = 1'b0; spi_cs_n = 1'b1;
        tx_valid = 1'b0; tx_data = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_outputs", 32'({spi_miso, rx_valid, tx_underrun, frame_abort, busy}), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_abort_cnt", 32'(abort_cnt), 32'd0);
        check("rst_tx_ready", 32'(tx_ready), 32'd1);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // Loaded response A5, host sends 3C
        offer(8'hA5);
        host_frame(8'h3C, 8, 1'b0, 1'b0, 8'h00);
        // Empty hold: underrun and FF
        host_frame(8'h81, 8, 1'b0, 1'b0, 8'h00);
        // Abort after three falls
        host_frame(8'hE7, 3, 1'b0, 1'b0, 8'h00);
        check("abort_cnt_first", 32'(abort_cnt), 32'(exp_abort_cnt()));
        // Offer in the frame-start cycle goes to the next frame
        host_frame(8'h42, 8, 1'b0, 1'b1, 8'h6E);
        host_frame(8'h99, 8, 1'b0, 1'b0, 8'h00);
        // CS release coinciding with the last fall completes the word
        host_frame(8'hC3, 8, 1'b1, 1'b0, 8'h00);

        // Reset in the middle of a frame, CS held low through release
        if (!m_full) begin
            e.kind = EV_UND; e.data = 8'h00; exp_q.push_back(e);
        end
        @(negedge clk);
        spi_cs_n = 1'b0;
        repeat (half) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            spi_mosi = 1'b1; spi_sclk = 1'b1;
            repeat (half) @(negedge clk);
            spi_sclk = 1'b0;
            repeat (half) @(negedge clk);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("midframe_rst_busy", 32'(busy), 32'd0);
        check("midframe_rst_rx_data", 32'(rx_data), 32'd0);
        m_full = 1'b0; m_rx = 8'h00; m_aborts = 0;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            spi_mosi = 1'b0; spi_sclk = 1'b1;
            repeat (half) @(negedge clk);
            spi_sclk = 1'b0;
            repeat (half) @(negedge clk);
        end
        check("ignored_frame_busy", 32'(busy), 32'd0);
        spi_cs_n = 1'b1;
        repeat (2 * half) @(negedge clk);
        check("after_rst_rx_data", 32'(rx_data), 32'd0);
        check("after_rst_abort_cnt", 32'(abort_cnt), 32'd0);
        host_frame(8'h5A, 8, 1'b0, 1'b0, 8'h00);

        // Randomized frames
        for (int f = 0; f < 24; f++) begin
            mo = 8'($urandom);
            case ($urandom_range(0, 9))
                0:       nb = 0;
                1, 2:    nb = $urandom_range(1, 7);
                default: nb = 8;
            endcase
            if (!m_full && $urandom_range(0, 1) == 1)
                offer(8'($urandom));
            host_frame(mo, nb, (nb == 8) && ($urandom_range(0, 3) == 0), 1'b0, 8'h00);
        end
        check("abort_cnt_random", 32'(abort_cnt), 32'(exp_abort_cnt()));

        // Saturation run at the fastest legal SCLK
        half = 4;
        for (int f = 0; f < 300; f++)
            host_frame(8'($urandom), $urandom_range(1, 7), 1'b0, 1'b0, 8'h00);
        check("abort_cnt_saturated", 32'(abort_cnt), 32'(exp_abort_cnt()));

        repeat (20) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
